// File: rtl/ika2151_dac_deserializer_pkg.sv
// Shared constants for the IKA2151 serial DAC receive path: word layout and FSM encoding.
package ika2151_dac_deserializer_pkg;

    localparam int unsigned FRAME_LEN_DEF = 32;
    localparam int unsigned WORD_W        = 13;
    localparam int unsigned PCM_W         = 16;

    localparam int unsigned MANT_LSB = 0;
    localparam int unsigned MANT_W   = 10;
    localparam int unsigned EXP_LSB  = 10;
    localparam int unsigned EXP_W    = 3;

    localparam logic [0:0] ST_WAIT_CH1 = 1'b0;
    localparam logic [0:0] ST_WAIT_CH2 = 1'b1;

endpackage

// File: rtl/ika2151_fp_to_linear.sv
// Combinational decode of a 13-bit DAC floating-point word into 16-bit signed linear PCM.
module ika2151_fp_to_linear
    import ika2151_dac_deserializer_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    output logic [PCM_W-1:0]  pcm_o
);

    logic [MANT_W-1:0] mant;
    logic [EXP_W-1:0]  expo;
    logic [MANT_W-1:0] m_signed;
    logic [PCM_W-1:0]  m_ext;

    always_comb begin
        mant     = word_i[MANT_LSB +: MANT_W];
        expo     = word_i[EXP_LSB +: EXP_W];
        // Mantissa is offset binary: flipping the MSB gives two's complement.
        m_signed = {~mant[MANT_W-1], mant[MANT_W-2:0]};
        m_ext    = {{(PCM_W - MANT_W){m_signed[MANT_W-1]}}, m_signed};
        if (expo == '0) begin
            pcm_o = '0;
        end else begin
            pcm_o = m_ext << (expo - 3'd1);
        end
    end

endmodule

// File: rtl/ika2151_dac_deserializer.sv
// Receives the SO/SH1/SH2 serial DAC stream, decodes both channels and tracks frame lock.
module ika2151_dac_deserializer
    import ika2151_dac_deserializer_pkg::*;
#(
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
    parameter int unsigned LOCK_CNT  = 2
) (
    input  logic              i_EMUCLK,
    input  logic              i_RST,
    input  logic              i_phi1_NCEN_n,
    input  logic              i_SO,
    input  logic              i_SH1,
    input  logic              i_SH2,
    output logic [PCM_W-1:0]  o_CH1,
    output logic [PCM_W-1:0]  o_CH2,
    output logic              o_SAMPLE_STB,
    output logic              o_LOCKED,
    output logic              o_FRAME_ERR
);

    localparam logic [1:0] LockMax = 2'(LOCK_CNT);

    logic [WORD_W-1:0] sr_q, sr_d;
    logic              sh1_q, sh1_d, sh2_q, sh2_d;
    logic [0:0]        state_q, state_d;
    logic [5:0]        per_q, per_d;
    logic              seen_q, seen_d;
    logic [1:0]        lock_q, lock_d;
    logic [PCM_W-1:0]  ch1_q, ch1_d, ch2_q, ch2_d;
    logic              stb_q, stb_d;
    logic              err_q, err_d;

    logic              en, fall1, fall2;
    logic [PCM_W-1:0]  pcm;

    // The word present before this enable's shift is the one being latched.
    ika2151_fp_to_linear u_dec (
        .word_i (sr_q),
        .pcm_o  (pcm)
    );

    always_comb begin
        en      = ~i_phi1_NCEN_n;
        fall1   = sh1_q & ~i_SH1;
        fall2   = sh2_q & ~i_SH2;
        sr_d    = sr_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        state_d = state_q;
        per_d   = per_q;
        seen_d  = seen_q;
        lock_d  = lock_q;
        ch1_d   = ch1_q;
        ch2_d   = ch2_q;
        stb_d   = 1'b0;
        err_d   = err_q;
        if (en) begin
            sr_d  = {i_SO, sr_q[WORD_W-1:1]};
            sh1_d = i_SH1;
            sh2_d = i_SH2;
            per_d = (per_q == 6'd63) ? per_q : per_q + 6'd1;
            if (i_SH1 && i_SH2) err_d = 1'b1;
            if (fall1) ch1_d = pcm;
            if (fall2) ch2_d = pcm;

            if (fall1 && fall2) begin
                err_d   = 1'b1;
                state_d = ST_WAIT_CH1;
            end else if (fall1) begin
                state_d = ST_WAIT_CH2;
            end else if (fall2 && state_q == ST_WAIT_CH2) begin
                stb_d   = 1'b1;
                state_d = ST_WAIT_CH1;
            end

            if (fall1) begin
                per_d  = '0;
                seen_d = 1'b1;
                if (seen_q) begin
                    if (32'(per_q) + 32'd1 == FRAME_LEN) begin
                        if (lock_q != LockMax) lock_d = lock_q + 2'd1;
                    end else begin
                        err_d  = 1'b1;
                        lock_d = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_EMUCLK or posedge i_RST) begin
        if (i_RST) begin
            sr_q    <= '0;
            sh1_q   <= 1'b0;
            sh2_q   <= 1'b0;
            state_q <= ST_WAIT_CH1;
            per_q   <= '0;
            seen_q  <= 1'b0;
            lock_q  <= '0;
            ch1_q   <= '0;
            ch2_q   <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            state_q <= state_d;
            per_q   <= per_d;
            seen_q  <= seen_d;
            lock_q  <= lock_d;
            ch1_q   <= ch1_d;
            ch2_q   <= ch2_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
        end
    end

    assign o_CH1        = ch1_q;
    assign o_CH2        = ch2_q;
    assign o_SAMPLE_STB = stb_q;
    assign o_LOCKED     = (lock_q == LockMax);
    assign o_FRAME_ERR  = err_q;

endmodule
